// File: rtl/lbp_sink.sv
// LBP result sink: checks the raster write-address sequence of an LBP
// producer, keeps a write count and checksum, and forwards every accepted
// write through a small first-word-fall-through FIFO to a valid/ready stream.
module lbp_sink #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lbp_valid,
  input  logic [13:0] lbp_addr,
  input  logic [7:0]  lbp_data,
  input  logic        finish,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [13:0] out_addr,
  output logic [7:0]  out_data,
  output logic [13:0] wr_count,
  output logic [15:0] checksum,
  output logic        addr_err,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CSUM_W = 16;
  localparam int unsigned COORD_W = 7;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(129);
  localparam logic [COORD_W-1:0] LAST_INNER_X = COORD_W'(126);
  localparam logic [COORD_W-1:0] EDGE_HI = COORD_W'(127);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  exp_q, exp_d;
  logic [ADDR_W-1:0]  wr_count_q, wr_count_d;
  logic [CSUM_W-1:0]  checksum_q, checksum_d;
  logic               addr_err_q, addr_err_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  entry_t             mem_q [FIFO_DEPTH];

  logic               take_c;
  logic               done_wr_c;
  logic               enter_done_c;
  logic               empty_c;
  logic               full_c;
  logic               pop_c;
  logic               push_c;
  logic               drop_c;
  logic               err_c;
  logic [COORD_W-1:0] x_c;
  logic [COORD_W-1:0] y_c;
  entry_t             wr_entry_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; finish takes precedence over the first write in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (finish) begin
          state_d = ST_DRAIN;
        end else if (lbp_valid) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (finish) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (empty_c && !lbp_valid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State-decoded controls: which writes count and when completion is entered
  always_comb begin
    take_c       = 1'b0;
    done_wr_c    = 1'b0;
    enter_done_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        take_c = lbp_valid;
      end
      ST_DRAIN: begin
        take_c       = lbp_valid;
        enter_done_c = (state_d == ST_DONE);
      end
      ST_DONE: begin
        done_wr_c = lbp_valid;
      end
      default: begin
        take_c = 1'b0;
      end
    endcase
  end

  // FIFO occupancy flags and push/pop/drop decisions
  always_comb begin
    empty_c = (count_q == CW'(0));
    full_c  = (count_q == CW'(FIFO_DEPTH));
    pop_c   = !empty_c && out_ready;
    push_c  = take_c && (!full_c || pop_c);
    drop_c  = take_c && full_c && !pop_c;
  end

  // Address-sequence and border check plus expected-address resync
  always_comb begin
    x_c   = lbp_addr[COORD_W-1:0];
    y_c   = lbp_addr[ADDR_W-1:COORD_W];
    err_c = 1'b0;
    exp_d = exp_q;
    if (lbp_valid) begin
      err_c = (lbp_addr != exp_q)
            || (x_c == '0) || (x_c == EDGE_HI)
            || (y_c == '0) || (y_c == EDGE_HI)
            || done_wr_c;
      if (x_c == LAST_INNER_X) begin
        exp_d = lbp_addr + ADDR_W'(3);
      end else begin
        exp_d = lbp_addr + ADDR_W'(1);
      end
    end
  end

  // Statistics and sticky flags next values
  always_comb begin
    wr_count_d = wr_count_q;
    checksum_d = checksum_q;
    addr_err_d = addr_err_q | err_c;
    overflow_d = overflow_q | drop_c;
    done_d     = done_q | enter_done_c;
    if (take_c) begin
      wr_count_d = wr_count_q + ADDR_W'(1);
      checksum_d = checksum_q + CSUM_W'(lbp_data);
    end
  end

  // FIFO pointer and occupancy next values
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_entry_c = '{addr: lbp_addr, data: lbp_data};
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Checker registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q      <= FIRST_ADDR;
      wr_count_q <= '0;
      checksum_q <= '0;
      addr_err_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      wr_count_q <= wr_count_d;
      checksum_q <= checksum_d;
      addr_err_q <= addr_err_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= wr_entry_c;
    end
  end

  assign out_valid = !empty_c;
  assign out_addr  = mem_q[rd_ptr_q].addr;
  assign out_data  = mem_q[rd_ptr_q].data;
  assign wr_count  = wr_count_q;
  assign checksum  = checksum_q;
  assign addr_err  = addr_err_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule
